// File: rtl/uart_tx_param.sv
// Parametrised UART serializer for the clk_3125 domain: configurable width, bit period, order and stop bits.
// Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry buffer in front of the serializer.
module uart_tx_param #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 27,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned MSB_FIRST    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                 clk_3125,
  input  logic                 rst,
  input  logic                 parity_en,
  input  logic                 parity_type,
  input  logic                 tx_start,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2) ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("uart_tx_param: illegal parameter value");
  end

  logic [2:0]           state;
  logic [CNT_W-1:0]     clk_cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_nxt;
  logic                 out_bit;
  logic                 par_bit;
  logic                 par_en_q;
  logic                 load;
  logic [DATA_BITS-1:0] load_data;

`ifdef UART_TX_FIFO_EN
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = FIFO_DEPTH[PTR_W:0];

  logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W:0]       fifo_cnt;
  logic                 fifo_full;
  logic                 push;
  logic                 pop;

  assign fifo_full = (fifo_cnt == FULL_CNT);
  assign tx_ready  = !fifo_full;
  assign push      = tx_start && !fifo_full;
  assign pop       = (state == S_IDLE) && (fifo_cnt != '0);
  assign load      = pop;
  assign load_data = fifo_mem[rd_ptr];

  always_ff @(posedge clk_3125) begin
    if (push) fifo_mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk_3125 or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end
`else
  assign tx_ready  = (state == S_IDLE);
  assign load      = tx_start && tx_ready;
  assign load_data = data;
`endif

  // The bit leaving next is always at the same end of shreg; the register shifts toward it.
  always_comb begin
    if (MSB_FIRST != 0) begin
      out_bit   = shreg[DATA_BITS-1];
      shreg_nxt = {shreg[DATA_BITS-2:0], 1'b0};
    end else begin
      out_bit   = shreg[0];
      shreg_nxt = {1'b0, shreg[DATA_BITS-1:1]};
    end
  end

  always_ff @(posedge clk_3125 or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      par_en_q <= 1'b0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state == S_IDLE) begin
        if (load) begin
          shreg    <= load_data;
          par_en_q <= parity_en;
          par_bit  <= parity_type ? ~^load_data : ^load_data;
          clk_cnt  <= '0;
          tx       <= 1'b0;
          tx_busy  <= 1'b1;
          state    <= S_START;
        end
      end else if (clk_cnt != CNT_LAST) begin
        clk_cnt <= clk_cnt + 1'b1;
      end else begin
        clk_cnt <= '0;
        case (state)
          S_START: begin
            tx      <= out_bit;
            shreg   <= shreg_nxt;
            bit_idx <= '0;
            state   <= S_DATA;
          end
          S_DATA: begin
            if (bit_idx != BIT_LAST) begin
              tx      <= out_bit;
              shreg   <= shreg_nxt;
              bit_idx <= bit_idx + 1'b1;
            end else if (par_en_q) begin
              tx    <= par_bit;
              state <= S_PARITY;
            end else begin
              tx       <= 1'b1;
              stop_idx <= 1'b0;
              state    <= S_STOP;
            end
          end
          S_PARITY: begin
            tx       <= 1'b1;
            stop_idx <= 1'b0;
            state    <= S_STOP;
          end
          S_STOP: begin
            if (stop_idx == STOP_LAST) begin
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
              state   <= S_IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end
          default: begin
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            state   <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: two instances (default and 7-bit/LSB-first/2-stop), a frame-level model
// compared every cycle, plus hand-computed waveform and timing expectations.
module tb_uart_tx_param;

  localparam int unsigned CPB_C  [2] = '{27, 4};
  localparam int unsigned DB_C   [2] = '{8, 7};
  localparam int unsigned MSB_C  [2] = '{1, 0};
  localparam int unsigned STOP_C [2] = '{1, 2};
  localparam int unsigned FIFO_D = 4;

  logic       clk;
  logic       rst;
  logic       start [2];
  logic       pe    [2];
  logic       pt    [2];
  logic [8:0] din   [2];
  logic       tx_a, tx_b, rdy_a, rdy_b, busy_a, busy_b, done_a, done_b;
  logic       tx_o [2], rdy [2], busy [2], done_o [2];

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(27), .STOP_BITS(1), .MSB_FIRST(1), .FIFO_DEPTH(4)) u_dut_a (
    .clk_3125(clk), .rst(rst), .parity_en(pe[0]), .parity_type(pt[0]), .tx_start(start[0]),
    .tx_ready(rdy_a), .data(din[0][7:0]), .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a));

  uart_tx_param #(.DATA_BITS(7), .CLKS_PER_BIT(4), .STOP_BITS(2), .MSB_FIRST(0), .FIFO_DEPTH(4)) u_dut_b (
    .clk_3125(clk), .rst(rst), .parity_en(pe[1]), .parity_type(pt[1]), .tx_start(start[1]),
    .tx_ready(rdy_b), .data(din[1][6:0]), .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b));

  assign tx_o[0] = tx_a;   assign tx_o[1] = tx_b;
  assign rdy[0] = rdy_a;   assign rdy[1] = rdy_b;
  assign busy[0] = busy_a; assign busy[1] = busy_b;
  assign done_o[0] = done_a; assign done_o[1] = done_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // Serial frame as a bit list, element 0 first on the line; unused tail stays 1 (stop/idle).
  function automatic logic [15:0] frame_bits(input logic [8:0] d, input int unsigned db,
                                            input int unsigned msb, input logic p_en, input logic p_odd);
    logic [15:0] b;
    int unsigned pos;
    logic par;
    b = '1;
    b[0] = 1'b0;
    pos = 1;
    par = 1'b0;
    for (int unsigned i = 0; i < db; i++) begin
      b[pos] = (msb != 0) ? d[db-1-i] : d[i];
      par = par ^ d[i];
      pos++;
    end
    if (p_en) b[pos] = p_odd ? ~par : par;
    return b;
  endfunction

  // Model state: active frame, cycle offset inside it, frame bits, pending-word buffer.
  logic        m_act  [2];
  logic        m_done [2];
  int unsigned m_k    [2];
  int unsigned m_len  [2];
  logic [15:0] m_bits [2];
  logic [8:0]  m_q    [2][8];
  int unsigned m_head [2];
  int unsigned m_cnt  [2];

  task automatic begin_frame(input int ch, input logic [8:0] d);
    m_bits[ch] = frame_bits(d, DB_C[ch], MSB_C[ch], pe[ch], pt[ch]);
    m_len[ch]  = 1 + DB_C[ch] + (pe[ch] ? 1 : 0) + STOP_C[ch];
    m_k[ch]    = 0;
    m_act[ch]  = 1'b1;
  endtask

  task automatic model_step(input int ch);
    logic pre_act;
    int unsigned pre_cnt;
    pre_act = m_act[ch];
    pre_cnt = m_cnt[ch];
    m_done[ch] = 1'b0;
    if (pre_act) begin
      if (m_k[ch] == m_len[ch] * CPB_C[ch] - 1) begin
        m_act[ch]  = 1'b0;
        m_done[ch] = 1'b1;
      end else begin
        m_k[ch]++;
      end
    end else begin
`ifdef UART_TX_FIFO_EN
      if (pre_cnt > 0) begin
        begin_frame(ch, m_q[ch][m_head[ch]]);
        m_head[ch] = (m_head[ch] + 1) % 8;
        m_cnt[ch]--;
      end
`else
      if (start[ch]) begin_frame(ch, din[ch]);
`endif
    end
`ifdef UART_TX_FIFO_EN
    if (start[ch] && pre_cnt < FIFO_D) begin
      m_q[ch][(m_head[ch] + m_cnt[ch]) % 8] = din[ch];
      m_cnt[ch]++;
    end
`else
    if (pre_cnt != 0) m_cnt[ch] = 0;
`endif
  endtask

  initial begin
    logic exp_tx, exp_rdy;
    for (int ch = 0; ch < 2; ch++) begin
      m_act[ch] = 1'b0; m_done[ch] = 1'b0; m_k[ch] = 0; m_len[ch] = 0;
      m_bits[ch] = '1; m_head[ch] = 0; m_cnt[ch] = 0;
    end
    forever begin
      @(posedge clk);
      for (int ch = 0; ch < 2; ch++) begin
        if (rst) begin
          m_act[ch] = 1'b0; m_done[ch] = 1'b0; m_head[ch] = 0; m_cnt[ch] = 0;
        end else begin
          model_step(ch);
        end
      end
      @(negedge clk);
      if (!rst) begin
        for (int ch = 0; ch < 2; ch++) begin
          exp_tx = m_act[ch] ? m_bits[ch][m_k[ch] / CPB_C[ch]] : 1'b1;
`ifdef UART_TX_FIFO_EN
          exp_rdy = (m_cnt[ch] < FIFO_D);
`else
          exp_rdy = !m_act[ch];
`endif
          check($sformatf("ch%0d_tx", ch),    32'(tx_o[ch]),   32'(exp_tx));
          check($sformatf("ch%0d_busy", ch),  32'(busy[ch]),   32'(m_act[ch]));
          check($sformatf("ch%0d_done", ch),  32'(done_o[ch]), 32'(m_done[ch]));
          check($sformatf("ch%0d_ready", ch), 32'(rdy[ch]),    32'(exp_rdy));
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge with tx_start low.
  task automatic send(input int ch, input logic [8:0] d, input logic p_en, input logic p_odd);
    int unsigned w;
    w = 0;
    din[ch] = d; pe[ch] = p_en; pt[ch] = p_odd; start[ch] = 1'b1;
    while (!rdy[ch] && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("send_ready_timeout", 32'(rdy[ch]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    start[ch] = 1'b0;
  endtask

  // Counts cycles from the start bit to tx_done and captures each bit at mid-period.
  task automatic measure(input int ch, output int unsigned cyc, output logic [15:0] cap);
    int unsigned cpb;
    cpb = CPB_C[ch];
    cyc = 0;
    cap = '1;
`ifdef UART_TX_FIFO_EN
    @(posedge clk);
    @(negedge clk);
`endif
    while (!done_o[ch] && cyc < 2000) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (cyc % cpb == cpb / 2) cap[cyc / cpb] = tx_o[ch];
    end
    @(posedge clk);
    @(negedge clk);
    check("done_one_cycle", 32'(done_o[ch]), 32'd0);
  endtask

  initial begin
    int unsigned cyc;
    logic [15:0] cap;
    int unsigned ndone;

    rst = 1'b1;
    for (int ch = 0; ch < 2; ch++) begin
      start[ch] = 1'b0; pe[ch] = 1'b0; pt[ch] = 1'b0; din[ch] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_tx",   32'(tx_a),   32'd1);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(rdy_a), 32'd1);

    // A5, even parity, MSB first
    send(0, 9'h0A5, 1'b1, 1'b0);
    measure(0, cyc, cap);
    check("t1_len",  cyc, 32'd297);
    check("t1_bits", 32'(cap[10:0]), 32'(11'b10101001010));

    // A5, odd parity
    send(0, 9'h0A5, 1'b1, 1'b1);
    measure(0, cyc, cap);
    check("t2_len_odd",  cyc, 32'd297);
    check("t2_bits_odd", 32'(cap[10:0]), 32'(11'b11101001010));

    // A5, no parity
    send(0, 9'h0A5, 1'b0, 1'b0);
    measure(0, cyc, cap);
    check("t2_len_nopar",  cyc, 32'd270);
    check("t2_bits_nopar", 32'(cap[10:0]), 32'(11'b11101001010));

    // 7-bit LSB-first, two stop bits, inputs disturbed mid-frame
    send(1, 9'h041, 1'b1, 1'b0);
    fork
      measure(1, cyc, cap);
      begin
        repeat (10) @(negedge clk);
        din[1] = '0; pe[1] = 1'b0; pt[1] = 1'b1;
      end
    join
    check("t3_len",  cyc, 32'd44);
    check("t3_bits", 32'(cap[10:0]), 32'(11'b11010000010));
    repeat (3) @(negedge clk);

    // Reset asserted mid-frame
    send(0, 9'h0FF, 1'b1, 1'b0);
    repeat (100) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t4_async_tx",   32'(tx_a),   32'd1);
    check("t4_async_busy", 32'(busy_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t4_ready_after", 32'(rdy_a), 32'd1);
    send(0, 9'h03C, 1'b1, 1'b0);
    measure(0, cyc, cap);
    check("t4_len",  cyc, 32'd297);
    check("t4_bits", 32'(cap[10:0]), 32'(11'b10001111000));
    repeat (3) @(negedge clk);

`ifndef UART_TX_FIFO_EN
    // tx_start held high: second word goes out after exactly one idle cycle
    send(0, 9'h001, 1'b1, 1'b0);
    din[0] = 9'h002;
    start[0] = 1'b1;
    ndone = 0;
    for (int i = 0; i < 800 && ndone < 2; i++) begin
      @(negedge clk);
      if (done_o[0]) begin
        ndone++;
        if (ndone == 1) begin
          @(posedge clk);
          @(negedge clk);
          check("t5_gap_start", 32'(tx_a), 32'd0);
          start[0] = 1'b0;
        end
      end
    end
    start[0] = 1'b0;
    check("t5_frames", ndone, 32'd2);
    repeat (30) @(negedge clk);
    check("t5_no_extra", 32'(busy_a), 32'd0);
`else
    // Six pushes on consecutive cycles into a 4-deep buffer
    for (int w = 0; w < 6; w++) begin
      din[0] = 9'(8'h10 + w);
      start[0] = 1'b1;
      @(negedge clk);
      if (w == 4) check("t6_full", 32'(rdy_a), 32'd0);
    end
    start[0] = 1'b0;
    ndone = 0;
    for (int i = 0; i < 5 * 297 + 60; i++) begin
      @(negedge clk);
      if (done_o[0]) ndone++;
    end
    check("t6_frames", ndone, 32'd5);
`endif

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
